// File: rtl/i2c_key_receiver_if.sv
// Key-code hand-off between the I2C receiver (master side, producer) and local
// logic (slave side, consumer), plus bus status.
`timescale 1ns/1ps
interface i2c_key_receiver_if;
  logic [7:0] key_data;
  logic       key_valid;
  logic       key_ready;
  logic       busy;
  logic       ovf_err;

  modport master (
    output key_data,
    output key_valid,
    output busy,
    output ovf_err,
    input  key_ready
  );

  modport slave (
    input  key_data,
    input  key_valid,
    input  busy,
    input  ovf_err,
    output key_ready
  );
endinterface

// File: rtl/i2c_key_receiver.sv
// Write-only I2C target: receives key-code bytes addressed to ADDR into a valid/ready
// holding register and NACKs any byte that arrives while the register is still full.
`timescale 1ns/1ps
module i2c_key_receiver #(
  parameter logic [6:0] ADDR = 7'h27
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scl,
  inout  wire                sda,
  i2c_key_receiver_if.master key
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StData, StDataAck, StIgnore
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] scl_q, sda_q;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q;
  logic       valid_q, ovf_q;
  logic       load, ovf_set;
  logic       scl_s, scl_p, sda_s, sda_p;
  logic       scl_rise, scl_fall, start, stop, byte_done, take;

  // Bits [1:0] synchronise, bit [2] is the history copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign scl_s     = scl_q[1];
  assign scl_p     = scl_q[2];
  assign sda_s     = sda_q[1];
  assign sda_p     = sda_q[2];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start     = scl_s & scl_p & sda_p & ~sda_s;
  assign stop      = scl_s & scl_p & ~sda_p & sda_s;
  assign byte_done = scl_fall && (cnt_q == 4'd8);
  assign take      = !valid_q || key.key_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    load    = 1'b0;
    ovf_set = 1'b0;

    if ((state_q == StAddr || state_q == StData) && scl_rise && (cnt_q != 4'd8)) begin
      shift_d = {shift_q[6:0], sda_s};
      cnt_d   = cnt_q + 4'd1;
    end

    case (state_q)
      StIdle: ;
      StAddr: begin
        if (byte_done) begin
          state_d = (shift_q == {ADDR, 1'b0}) ? StAddrAck : StIgnore;
        end
      end
      StAddrAck, StDataAck: begin
        if (scl_fall) begin
          state_d = StData;
          cnt_d   = 4'd0;
        end
      end
      StData: begin
        if (byte_done) begin
          if (take) begin
            load    = 1'b1;
            state_d = StDataAck;
          end else begin
            ovf_set = 1'b1;
            state_d = StIgnore;
          end
        end
      end
      StIgnore: ;
      default: state_d = StIdle;
    endcase

    // Bus conditions override whatever the byte engine was doing.
    if (start) begin
      state_d = StAddr;
      cnt_d   = 4'd0;
      load    = 1'b0;
      ovf_set = 1'b0;
    end else if (stop) begin
      state_d = StIdle;
      load    = 1'b0;
      ovf_set = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_set;
      if (load) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && key.key_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Open drain: only ever pull low, and only while acknowledging.
  assign sda = (state_q == StAddrAck || state_q == StDataAck) ? 1'b0 : 1'bz;

  assign key.key_data  = data_q;
  assign key.key_valid = valid_q;
  assign key.busy      = (state_q != StIdle);
  assign key.ovf_err   = ovf_q;

endmodule

// File: doc/i2c_key_receiver.md
Name: i2c_key_receiver

Overview:
- I2C target (slave) receive-only block; the far end of the keyboard link driven by the I2C master.
- Watches the externally driven SCL/SDA lines and matches a 7-bit target address.
- Accepts write bytes (key codes), ACKs them, and presents each byte to the local logic on a valid/ready interface.
- NACKs bytes it cannot hold.

Parameters:
- ADDR, 7'h27, 7-bit I2C target address this block responds to (write only).

Ports:
- clk  input  1  system clock; must run at least 8x the SCL frequency.
- rst  input  1  synchronous, active-low reset.
- scl  input  1  I2C clock line from master (asynchronous to clk).
- sda  inout  1  I2C data line, open-drain: block drives 1'b0 or 1'bz only.
- key_data  output  8  last accepted byte; stable while key_valid=1.
- key_valid  output  1  byte available in holding register.
- key_ready  input  1  consumer accepts key_data when key_valid=1 and key_ready=1 on a clk edge.
- busy  output  1  high from detected START until detected STOP.
- ovf_err  output  1  one-cycle pulse when a data byte is NACKed because the holding register is full.

Behaviour:
- Input synchronisation:
  - scl and sda each pass through 2 flops, plus one history flop for edge detection.
  - Synchroniser flops reset to 1.
  - Line-to-detection latency is 3 clk cycles.
- Events are evaluated on synchronised signals:
  - START: sda 1->0 while scl=1.
  - STOP: sda 0->1 while scl=1.
  - SCL_RISE and SCL_FALL: scl edges.
- Bits are sampled on SCL_RISE, MSB first, into an 8-bit shift register. A 4-bit counter counts bits 0..8.
- State machine: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE: on START -> ADDR; clear counter.
  - ADDR: after the 8th SCL_RISE, wait for SCL_FALL, then:
    - if shift[7:1]==ADDR and shift[0]==0: drive sda low, -> ADDR_ACK.
    - otherwise (address mismatch, or read address with R/W=1): sda stays released, -> IGNORE.
  - ADDR_ACK: hold sda low through the 9th SCL pulse. On the next SCL_FALL, release sda, clear counter, -> DATA.
  - DATA: after the 8th SCL_RISE, wait for SCL_FALL, then:
    - if key_valid=0, or key_valid=1 with key_ready=1 this cycle: load key_data<=shift, set key_valid=1, drive sda low, -> DATA_ACK.
    - otherwise: release sda, pulse ovf_err, -> IGNORE.
  - DATA_ACK: same as ADDR_ACK, returning to DATA for the next byte.
  - IGNORE: sda released; wait for START or STOP.
- START in any state (repeated start, including mid-byte) -> ADDR: counter cleared, sda released, holding register untouched.
- STOP in any state -> IDLE, sda released. A partial byte is discarded.
- Handshake:
  - key_valid clears on the clk edge where key_valid=1 and key_ready=1, unless a new byte loads in that same cycle (then key_valid stays 1 with the new data).
  - key_data never changes while key_valid=1 except through that simultaneous load.
- busy: 1 in every state except IDLE.
- Reset (rst=0 at a clk edge), effective on that edge even mid-transfer or mid-ACK:
  - state=IDLE, sda released (z), key_data=8'h00, key_valid=0, busy=0, ovf_err=0, counter=0, shift=0.
- The block never drives sda high and never stretches SCL.

Test Plan:
- Bench setup: clk period 10 ns, SCL period 400 ns, pull-up on sda.
- Reset then idle: rst=0 for 2 cycles -> all outputs 0, sda=z; bus idle for 1 us -> busy=0.
- Nominal write:
  - Stimulus: START, 0x4E, 0xA5, STOP; key_ready=1 held.
  - Response: ACK on both 9th clocks (sda=0); key_data=8'hA5; key_valid high 1 cycle; busy low 3 cycles after STOP.
- Address mismatch and read:
  - Stimulus: START, 0x50, STOP; then START, 0x4F, STOP.
  - Response: sda=z during both 9th clocks; key_valid stays 0; ovf_err stays 0.
- Overflow:
  - Stimulus: key_ready=0; START, 0x4E, 0xA5, 0x5A, STOP.
  - Response: 0xA5 ACKed; 0x5A NACKed; ovf_err pulses once; key_data=8'hA5 and key_valid=1 remain.
  - Then key_ready=1 for 1 cycle -> key_valid=0.
- Repeated start:
  - Stimulus: START, 0x4E, 4 bits of data, START, 0x4E, 0x3C, STOP.
  - Response: partial byte discarded; key_data=8'h3C; one key_valid assertion.
- Reset mid-ACK:
  - Stimulus: assert rst=0 while block drives the ACK for 0x4E.
  - Response: sda=z on the next clk edge; state IDLE; a subsequent data byte is ignored until a new START.
